// File: rtl/uart_tx_fifo_sender_if.sv
// uart_tx_fifo_sender_if: host-side word/flag bundle of the UART transmitter; Send_Break exists only with UART_TX_BREAK_EN.
interface uart_tx_fifo_sender_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] Tx_Data;
  logic Write_En, CTS, Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow;
`ifdef UART_TX_BREAK_EN
  logic Send_Break;
  modport master (output Tx_Data, Write_En, CTS, Send_Break, input Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow);
  modport slave (input Tx_Data, Write_En, CTS, Send_Break, output Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow);
`else
  modport master (output Tx_Data, Write_En, CTS, input Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow);
  modport slave (input Tx_Data, Write_En, CTS, output Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow);
`endif
endinterface

// File: rtl/uart_tx_fifo_sender.sv
// uart_tx_fifo_sender: FIFO-fed UART transmitter (start, data MSB first, even parity, stop bits) with CTS flow control.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo_sender #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_BIT = 1,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input logic Clk,
  input logic Rst,
  uart_tx_fifo_sender_if.slave bus
);
  localparam int FB = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * FB);
  typedef enum logic [1:0] {IDLE, SHIFT, BREAK} state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_q, full_q, ovf_q;
  logic [FB-1:0] sh_q, sh_d, frame;
  logic [CW-1:0] bit_q, bit_d;
  logic brk_req, boundary, pop, push;
`ifdef UART_TX_BREAK_EN
  assign brk_req = bus.Send_Break;
`else
  assign brk_req = 1'b0;
`endif
  if (PARITY_BIT != 0) begin : g_par
    assign frame = {1'b0, mem_q[rd_q], ^mem_q[rd_q], {STOP_BITS{1'b1}}};
  end else begin : g_nopar
    assign frame = {1'b0, mem_q[rd_q], {STOP_BITS{1'b1}}};
  end
  // CTS and break requests are only looked at between frames
  assign boundary = state_q == IDLE || (state_q == SHIFT && bit_q == CW'(FB - 1));
  assign pop = boundary && !brk_req && !empty_q && cnt_q != '0 && bus.CTS;
  assign push = bus.Write_En && (cnt_q != (AW+1)'(FIFO_DEPTH) || pop);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '1;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      empty_q <= cnt_q == '0;
      full_q <= cnt_q >= (AW+1)'(FIFO_DEPTH / 2 + 1);
      ovf_q <= ovf_q | (bus.Write_En & ~push);
    end
  end
  always_ff @(posedge Clk) if (push) mem_q[wr_q] <= bus.Tx_Data;
  always_comb begin
    sh_d = pop ? frame : {sh_q[FB-2:0], 1'b1};
    bit_d = boundary ? '0 : bit_q + 1'b1;
    state_d = boundary ? (brk_req ? BREAK : pop ? SHIFT : IDLE)
            : (state_q == BREAK && bit_q == CW'(2 * FB - 1)) ? IDLE : state_q;
  end
  always_comb begin
    bus.Tx = state_q == SHIFT ? sh_q[FB-1] : state_q != BREAK;
    bus.Tx_Busy = state_q != IDLE;
    bus.FIFO_Empty = empty_q;
    bus.FIFO_Full = full_q;
    bus.FIFO_Overflow = ovf_q;
  end
endmodule

// File: tb/tb_uart_tx_fifo_sender.sv
// tb_uart_tx_fifo_sender: scoreboard bench; words queued at push, frames decoded off Tx and compared on completion.
module tb_uart_tx_fifo_sender;
  localparam int DB = 8, FB = 12, DEPTH = 8;
  logic Clk = 1'b0, Rst = 1'b1;
  uart_tx_fifo_sender_if #(.DATA_BITS(DB)) bus();
  uart_tx_fifo_sender #(.DATA_BITS(DB), .PARITY_BIT(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  int checks = 0, errors = 0, cyc = 0, frames = 0, nb = 0, busy_len = 0, last_start = 0, mcount = 0;
  bit in_frame = 0, exp_ovf = 0;
  logic [FB-1:0] got;
  logic [DB-1:0] exp_q[$];
  int runs_q[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge Clk) cyc++;
  always @(negedge Clk) begin
    if (Rst) begin
      in_frame = 0;
      busy_len = 0;
    end else begin
      if (bus.Tx_Busy) busy_len++;
      else begin
        if (busy_len != 0) runs_q.push_back(busy_len);
        busy_len = 0;
        check("idle_tx", bus.Tx, 1);
      end
      if (!in_frame && bus.Tx === 1'b0) begin
        in_frame = 1;
        nb = 0;
        last_start = cyc;
        mcount--;
      end
      if (in_frame) begin
        check("busy_in_frame", bus.Tx_Busy, 1);
        got = {got[FB-2:0], bus.Tx};
        nb++;
        if (nb == FB) begin
          logic [DB-1:0] w;
          in_frame = 0;
          frames++;
          if (exp_q.size() == 0) check("spurious_frame", exp_q.size(), 1);
          else begin
            w = exp_q.pop_front();
            check("frame", got, {1'b0, w, ^w, 2'b11});
          end
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic push(input logic [DB-1:0] w);
    bus.Tx_Data = w;
    bus.Write_En = 1'b1;
    if (mcount < DEPTH) begin
      exp_q.push_back(w);
      mcount++;
    end else exp_ovf = 1;
    tick();
    bus.Write_En = 1'b0;
  endtask
  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 1000) begin
      tick();
      n++;
    end
    check("frames_done", frames, target);
  endtask
  task automatic wait_bit(input int b);
    int n = 0;
    while (!(in_frame && nb >= b) && n < 100) begin
      tick();
      n++;
    end
    check("bit_reached", in_frame && nb >= b, 1);
  endtask
  task automatic check_run(input int exp);
    check("busy_run", runs_q.size() != 0 ? runs_q.pop_front() : 0, exp);
  endtask
  task automatic do_reset();
    Rst = 1'b1;
    exp_q.delete();
    mcount = 0;
    exp_ovf = 0;
    tick();
    Rst = 1'b0;
  endtask
  initial begin
    int base, pc;
    bus.Tx_Data = '0;
    bus.Write_En = 1'b0;
    bus.CTS = 1'b1;
`ifdef UART_TX_BREAK_EN
    bus.Send_Break = 1'b0;
`endif
    tick(2);
    check("rst_tx", bus.Tx, 1);
    check("rst_busy", bus.Tx_Busy, 0);
    check("rst_empty", bus.FIFO_Empty, 1);
    check("rst_full", bus.FIFO_Full, 0);
    check("rst_ovf", bus.FIFO_Overflow, 0);
    Rst = 1'b0;
    tick(2);
    push(8'hA5);
    pc = cyc;
    wait_frames(1);
    check("latency", last_start - pc, 2);
    tick(3);
    check_run(12);
    push(8'h01);
    push(8'h80);
    wait_frames(3);
    tick(3);
    check_run(24);
    bus.CTS = 1'b0;
    foreach (exp_q[i]) check("q_clean", 0, 1);
    for (int i = 1; i <= 5; i++) push(DB'(i * 16 + i));
    tick(2);
    check("cts_hold_tx", bus.Tx, 1);
    check("cts_hold_busy", bus.Tx_Busy, 0);
    check("full5", bus.FIFO_Full, 1);
    check("nonempty5", bus.FIFO_Empty, 0);
    bus.CTS = 1'b1;
    wait_frames(8);
    tick(3);
    check_run(60);
    check("empty_after", bus.FIFO_Empty, 1);
    check("full_after", bus.FIFO_Full, 0);
    bus.CTS = 1'b0;
    check("ovf_pre", bus.FIFO_Overflow, 0);
    for (int i = 0; i <= 8; i++) push(DB'(i));
    tick(2);
    check("ovf_set", bus.FIFO_Overflow, exp_ovf);
    bus.CTS = 1'b1;
    wait_frames(16);
    tick(20);
    check("no_ninth", frames, 16);
    check("ovf_sticky", bus.FIFO_Overflow, 1);
    check_run(96);
    do_reset();
    tick();
    check("ovf_cleared", bus.FIFO_Overflow, 0);
    push(8'h3C);
    push(8'hC3);
    wait_bit(5);
    bus.CTS = 1'b0;
    wait_frames(17);
    tick(15);
    check("cts_withheld", frames, 17);
    check("cts_idle_busy", bus.Tx_Busy, 0);
    check_run(12);
    bus.CTS = 1'b1;
    wait_frames(18);
    tick(3);
    check_run(12);
    for (int i = 0; i < 4; i++) push(DB'(8'h55 + i));
    wait_bit(7);
    base = frames;
    do_reset();
    check("rst_mid_tx", bus.Tx, 1);
    check("rst_mid_busy", bus.Tx_Busy, 0);
    tick();
    check("rst_mid_empty", bus.FIFO_Empty, 1);
    tick(40);
    check("rst_no_frames", frames, base);
    check("rst_no_run", runs_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
